// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read control stages.
// Functions work on a fixed maximum width; callers zero-extend their pointer
// into ptr_max_t and size-cast the result back to their own pointer width.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // Binary to reflected Gray code.
    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary: prefix XOR from the MSB downwards,
    // done as log2(width) shift/XOR steps instead of a bit-serial chain.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = g;
        for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Producer-facing and memory-facing signals of the FIFO write-control stage.
// The master modport is the environment (producer, read domain, memory);
// the slave modport is the write-control block itself.
interface fifo_wptr_full_if #(
    parameter int unsigned ADDR_SIZE = 3
);

    logic                 w_inc;
    logic [ADDR_SIZE:0]   r_ptr;
    logic                 w_en;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [ADDR_SIZE:0]   w_ptr;
    logic                 w_full;
    logic                 w_almost_full;
    logic [ADDR_SIZE:0]   w_level;

    modport master (
        output w_inc,
        output r_ptr,
        input  w_en,
        input  w_addr,
        input  w_ptr,
        input  w_full,
        input  w_almost_full,
        input  w_level
    );

    modport slave (
        input  w_inc,
        input  r_ptr,
        output w_en,
        output w_addr,
        output w_ptr,
        output w_full,
        output w_almost_full,
        output w_level
    );

endinterface

// File: rtl/fifo_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into this clock
// domain. Shared by the write-full and read-empty control stages.
module fifo_sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    // Two-stage capture of the foreign-domain pointer, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side control of the async FIFO. Owns the binary/Gray write pointer,
// drives the memory write strobe/address, and derives registered full,
// almost-full and fill level from the synchronized read pointer.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE          = 3,
    parameter int unsigned ALMOST_FULL_MARGIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_wptr_full_if.slave       bus
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    typedef logic [ADDR_SIZE:0] ptr_t;

    localparam ptr_t AF_LEVEL = ptr_t'(DEPTH - ALMOST_FULL_MARGIN);
    // The two MSBs of a Gray pointer flip when the binary pointer is one
    // full lap (DEPTH entries) ahead; this mask builds that comparison value.
    localparam ptr_t FULL_MASK = ptr_t'(3) << (ADDR_SIZE - 1);

    ptr_t wbin_q,  wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t level_q, level_d;
    logic full_q,  full_d;
    logic afull_q, afull_d;

    ptr_t rq2;
    ptr_t rbin;
    logic w_en;

    fifo_sync2 #(
        .WIDTH (ADDR_SIZE + 1)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.r_ptr),
        .q_o   (rq2)
    );

    // A write while full is silently dropped: the strobe is simply withheld.
    assign w_en = bus.w_inc & ~full_q;

    // Next pointer values and status computed from the synchronized read pointer.
    always_comb begin
        wbin_d  = wbin_q + ptr_t'(w_en);
        wgray_d = ptr_t'(bin2gray(ptr_max_t'(wbin_d)));
        rbin    = ptr_t'(gray2bin(ptr_max_t'(rq2)));
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == (rq2 ^ FULL_MASK));
        afull_d = (level_d >= AF_LEVEL);
    end

    // Pointer and status registers; reset discards all pointer state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    assign bus.w_en          = w_en;
    assign bus.w_addr        = wbin_q[ADDR_SIZE-1:0];
    assign bus.w_ptr         = wgray_q;
    assign bus.w_full        = full_q;
    assign bus.w_almost_full = afull_q;
    assign bus.w_level       = level_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_SIZE=3, margin 1).
// The reference model tracks unbounded write/read counts; the read count the
// write side can see is the one driven two edges earlier.
module tb_fifo_wptr_full;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 1;

    logic clk;
    logic rst_n;

    fifo_wptr_full_if #(.ADDR_SIZE(3)) bus ();

    fifo_wptr_full #(
        .ADDR_SIZE          (3),
        .ALMOST_FULL_MARGIN (MARGIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int wcount = 0;       // total accepted writes since reset
    int rcount = 0;       // total reads performed by the read side
    int seen_q[$];        // read counts in flight toward the write side
    bit m_full = 0;
    bit m_af   = 0;
    int m_level = 0;

    function automatic int gray4(input int n);
        int b;
        b = n % 16;
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the combinational strobe, clock, update
    // the model and compare every registered output.
    task automatic step(input logic inc, input logic rst);
        logic [3:0] prev_ptr;
        int seen;
        int acc;
        @(negedge clk);
        rst_n       = rst;
        bus.w_inc   = inc;
        bus.r_ptr   = 4'(gray4(rcount));
        #1;
        check("w_en", 32'(bus.w_en), 32'(inc && !m_full));
        prev_ptr = bus.w_ptr;
        @(posedge clk);
        if (!rst) begin
            wcount  = 0;
            seen_q  = '{0, 0};
            m_level = 0;
            m_full  = 0;
            m_af    = 0;
            acc     = 0;
        end else begin
            acc     = (inc && !m_full) ? 1 : 0;
            wcount += acc;
            seen    = seen_q.pop_front();
            seen_q.push_back(rcount);
            m_level = wcount - seen;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= DEPTH - MARGIN);
        end
        #1;
        check("w_addr",  32'(bus.w_addr),        32'(wcount % DEPTH));
        check("w_ptr",   32'(bus.w_ptr),         32'(gray4(wcount)));
        check("w_full",  32'(bus.w_full),        32'(m_full));
        check("w_af",    32'(bus.w_almost_full), 32'(m_af));
        check("w_level", 32'(bus.w_level),       32'(m_level));
        if (rst) check("hamming", 32'($countones(bus.w_ptr ^ prev_ptr)), 32'(acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        bus.w_inc = 1'b0;
        bus.r_ptr = '0;
        seen_q    = '{0, 0};

        // Reset with a pending write request: nothing advances.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_ptr",   32'(bus.w_ptr),   32'h0);
        check("rst_level", 32'(bus.w_level), 32'h0);

        // Fill to full with no reads.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        check("fill_full",  32'(bus.w_full),  32'h1);
        check("fill_level", 32'(bus.w_level), 32'h8);
        check("fill_ptr",   32'(bus.w_ptr),   32'hC);
        check("fill_addr",  32'(bus.w_addr),  32'h0);
        step(1'b1, 1'b1);
        check("ovf_ptr",    32'(bus.w_ptr),   32'hC);

        // One read: full releases on the third edge.
        rcount = 1;
        step(1'b0, 1'b1);
        check("drain_e1", 32'(bus.w_full), 32'h1);
        step(1'b0, 1'b1);
        check("drain_e2", 32'(bus.w_full), 32'h1);
        step(1'b0, 1'b1);
        check("drain_e3",  32'(bus.w_full),  32'h0);
        check("drain_lvl", 32'(bus.w_level), 32'h7);
        step(1'b1, 1'b1);
        check("refill", 32'(bus.w_full), 32'h1);

        // Almost-full threshold at DEPTH-1.
        rcount = 0;
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        check("af6", 32'(bus.w_almost_full), 32'h0);
        step(1'b1, 1'b1);
        check("af7",      32'(bus.w_almost_full), 32'h1);
        check("af7_full", 32'(bus.w_full),        32'h0);

        // Long run across the pointer wrap with the reader lagging by 2.
        rcount = 0;
        step(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            rcount = (wcount >= 2) ? wcount - 2 : 0;
            step(1'b1, 1'b1);
            check("wrap_nofull", 32'(bus.w_full), 32'h0);
        end
        check("wrap_count", 32'(bus.w_ptr), 32'(gray4(40)));

        // Reset in the middle of operation.
        rcount = 0;
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check("mid_level", 32'(bus.w_level), 32'h5);
        step(1'b1, 1'b0);
        check("mid_rst_addr",  32'(bus.w_addr),  32'h0);
        check("mid_rst_level", 32'(bus.w_level), 32'h0);
        step(1'b1, 1'b1);
        check("mid_after", 32'(bus.w_addr), 32'h1);

        // Randomized traffic with random read progress and rare resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rcount = 0;
                step(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                if ($urandom_range(0, 2) != 0 && rcount < wcount) rcount++;
                if ($urandom_range(0, 4) == 0 && rcount < wcount) rcount++;
                step(1'($urandom_range(0, 3) != 0), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
